branch_predict_resolve: RTL

- Parametrised successor to the single-cycle PC-source decoder, for the pipelined core.
- Fetch side: predicts next PC from a 2-bit-counter branch history table (BHT) plus predecoded immediate.
- Execute side: resolves the full RV32I branch set (BEQ/BNE/BLT/BGE/BLTU/BGEU), JAL and JALR.
- Issues a registered redirect on mispredict, trains the BHT, and squashes wrong-path resolutions for a fixed window.

---
 rtl/branch_predict_resolve_if.sv | 37 +++
 rtl/branch_predict_resolve.sv | 132 +++++++++++++
 2 files changed

// File: rtl/branch_predict_resolve_if.sv
// Fetch-side prediction and execute-side resolution bundle for branch_predict_resolve.
// master drives the fetch/EX inputs; slave is the predictor/resolver.
interface branch_predict_resolve_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] f_pc;
    logic [6:0]      f_op;
    logic [XLEN-1:0] f_imm;
    logic [XLEN-1:0] f_pc_next;
    logic            f_pred_taken;

    logic            ex_valid;
    logic [6:0]      ex_op;
    logic [2:0]      ex_funct3;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1;
    logic [XLEN-1:0] ex_rs2;
    logic [XLEN-1:0] ex_imm;
    logic            ex_pred_taken;
    logic [1:0]      ex_pc_src;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output f_pc, f_op, f_imm,
        input  f_pc_next, f_pred_taken,
        output ex_valid, ex_op, ex_funct3, ex_pc, ex_rs1, ex_rs2, ex_imm, ex_pred_taken,
        input  ex_pc_src, redirect, redirect_pc
    );

    modport slave (
        input  f_pc, f_op, f_imm,
        output f_pc_next, f_pred_taken,
        input  ex_valid, ex_op, ex_funct3, ex_pc, ex_rs1, ex_rs2, ex_imm, ex_pred_taken,
        output ex_pc_src, redirect, redirect_pc
    );
endinterface

// File: rtl/branch_predict_resolve.sv
// BHT-based next-PC predictor with RV32I branch/jump resolution, registered redirect and squash window.
// Optional macro BRANCH_PERF_CNT_EN adds perf_branches / perf_mispredicts counters.
module branch_predict_resolve #(
    parameter int         XLEN         = 32,
    parameter int         BHT_IDX_W    = 6,
    parameter logic [1:0] BHT_INIT     = 2'b01,
    parameter int         FLUSH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    branch_predict_resolve_if.slave bus
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0]             perf_branches,
    output logic [31:0]             perf_mispredicts
`endif
);

    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam int         BHT_N   = 1 << BHT_IDX_W;
    localparam int         SQ_W    = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    logic [1:0]           bht [BHT_N];
    logic [SQ_W-1:0]      squash_cnt;
    logic [BHT_IDX_W-1:0] f_idx;
    logic [BHT_IDX_W-1:0] ex_idx;
    logic                 f_pred;

    logic            is_b, is_jal, is_jalr;
    logic            b_legal, b_taken;
    logic            accepted, mispredict;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;

    assign f_idx  = bus.f_pc[BHT_IDX_W+1:2];
    assign ex_idx = bus.ex_pc[BHT_IDX_W+1:2];

    // Fetch reads the pre-edge counter; a same-index update only lands at the clock edge.
    always_comb begin
        f_pred = ((bus.f_op == OP_B) && bht[f_idx][1]) || (bus.f_op == OP_JAL);
        bus.f_pred_taken = f_pred;
        bus.f_pc_next    = f_pred ? (bus.f_pc + bus.f_imm) : (bus.f_pc + XLEN'(4));
    end

    always_comb begin
        is_b    = (bus.ex_op == OP_B);
        is_jal  = (bus.ex_op == OP_JAL);
        is_jalr = (bus.ex_op == OP_JALR);
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        b_taken = 1'b0;
        b_legal = is_b;
        case (bus.ex_funct3)
            3'b000:  b_taken = (bus.ex_rs1 == bus.ex_rs2);
            3'b001:  b_taken = (bus.ex_rs1 != bus.ex_rs2);
            3'b100:  b_taken = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
            3'b101:  b_taken = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
            3'b110:  b_taken = (bus.ex_rs1 <  bus.ex_rs2);
            3'b111:  b_taken = (bus.ex_rs1 >= bus.ex_rs2);
            default: b_legal = 1'b0;
        endcase
        b_taken = b_taken && b_legal;
    end

    assign accepted = bus.ex_valid && (squash_cnt == '0);

    always_comb begin
        bus.ex_pc_src = 2'b00;
        if (accepted) begin
            if (is_jalr)                 bus.ex_pc_src = 2'b10;
            else if (is_jal || b_taken)  bus.ex_pc_src = 2'b01;
        end
    end

    assign mispredict = accepted &&
                        ((b_legal && (b_taken != bus.ex_pred_taken)) ||
                         (is_jal && !bus.ex_pred_taken) ||
                         is_jalr);

    assign jalr_sum = bus.ex_rs1 + bus.ex_imm;

    always_comb begin
        if (is_jalr)                 target = {jalr_sum[XLEN-1:1], 1'b0};
        else if (is_jal || b_taken)  target = bus.ex_pc + bus.ex_imm;
        else                         target = bus.ex_pc + XLEN'(4);
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.redirect    <= 1'b0;
            bus.redirect_pc <= '0;
            squash_cnt      <= '0;
        end else begin
            bus.redirect <= mispredict;
            if (mispredict) begin
                bus.redirect_pc <= target;
                squash_cnt      <= SQ_W'(FLUSH_CYCLES);
            end else if (squash_cnt != '0) begin
                squash_cnt <= squash_cnt - SQ_W'(1);
            end
        end
    end

    // NOTE: the BHT is built from flops rather than RAM so that reset can restore every counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_N; i++) bht[i] <= BHT_INIT;
        end else if (accepted && b_legal) begin
            if (b_taken && (bht[ex_idx] != 2'b11))
                bht[ex_idx] <= bht[ex_idx] + 2'b01;
            else if (!b_taken && (bht[ex_idx] != 2'b00))
                bht[ex_idx] <= bht[ex_idx] - 2'b01;
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (accepted && (b_legal || is_jal || is_jalr))
                perf_branches <= perf_branches + 32'd1;
            if (mispredict)
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif

endmodule
